// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// -----------------
// Operand-fetch stage that sits in front of a simple ALU. It holds the
// architectural register file, tracks which registers still have a result
// in flight (busy scoreboard), stalls instructions that touch a pending
// register, and presents a registered operand bundle to the ALU through a
// valid/ready handshake. No arithmetic is done here; operands pass through
// at full 32-bit width.
//
// Build option:
//   ALU_OPERAND_BYPASS_EN  when defined, a write-back in the same cycle as an
//                          instruction that reads the written register is
//                          forwarded into the captured operand, and that
//                          register does not stall. When undefined, the
//                          instruction waits one cycle and reads the updated
//                          register file instead.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake (in_ready ignores in_valid)
//   in_op, in_rs, in_rt, in_rd
//                         opcode, source A/B and destination indices
//   out_valid / out_ready operand-bundle handshake toward the ALU
//   out_a, out_b          operand values
//   out_op, out_rd        opcode and destination passed through
//   wb_en, wb_rd, wb_data, wb_zero
//                         write-back of an ALU result and its zero flag
//   zero_flag             zero flag of the last register write-back
//   busy                  scoreboard, bit i set = register i result pending

module alu_operand_stage #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_op,
   output logic [4:0]  out_rd,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        wb_zero,
   output logic        zero_flag,
   output logic [31:0] busy
);

`ifdef ALU_OPERAND_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [31:0] rf_q [NREG];
   logic [31:0] busy_q, busy_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_a_q, out_a_d;
   logic [31:0] out_b_q, out_b_d;
   logic [2:0]  out_op_q, out_op_d;
   logic [4:0]  out_rd_q, out_rd_d;
   logic        zero_q, zero_d;

   logic        wb_hit;
   logic        haz_rs, haz_rt, haz_rd, hazard;
   logic        accept;
   logic [31:0] opnd_a, opnd_b;

   // Write-back to register 0 is discarded entirely.
   assign wb_hit = wb_en && (wb_rd != 5'd0);

   always_comb begin
      // A source register being written back this cycle is not a hazard
      // when bypass is built in: the forwarded value is captured directly.
      haz_rs = (in_rs != 5'd0) && busy_q[in_rs] &&
               !(BYPASS && wb_hit && (wb_rd == in_rs));
      haz_rt = (in_rt != 5'd0) && busy_q[in_rt] &&
               !(BYPASS && wb_hit && (wb_rd == in_rt));
      haz_rd = (in_rd != 5'd0) && busy_q[in_rd];
      hazard = haz_rs || haz_rt || haz_rd;
   end

   assign in_ready = (!out_valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // Operand read: r0 is hard zero, indices outside the file read as zero.
   always_comb begin
      opnd_a = 32'd0;
      if (in_rs != 5'd0) begin
         if (BYPASS && wb_hit && (wb_rd == in_rs)) begin
            opnd_a = wb_data;
         end else if (int'(in_rs) < NREG) begin
            opnd_a = rf_q[in_rs];
         end
      end
      opnd_b = 32'd0;
      if (in_rt != 5'd0) begin
         if (BYPASS && wb_hit && (wb_rd == in_rt)) begin
            opnd_b = wb_data;
         end else if (int'(in_rt) < NREG) begin
            opnd_b = rf_q[in_rt];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_op_d    = out_op_q;
      out_rd_d    = out_rd_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_a_d     = opnd_a;
         out_b_d     = opnd_b;
         out_op_d    = in_op;
         out_rd_d    = in_rd;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Clear from write-back first so that a same-cycle set on the same
   // register wins and the register stays pending.
   always_comb begin
      busy_d = busy_q;
      zero_d = zero_q;
      if (wb_hit) begin
         busy_d[wb_rd] = 1'b0;
         zero_d        = wb_zero;
      end
      if (accept && (in_rd != 5'd0)) begin
         busy_d[in_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_a_q     <= 32'd0;
         out_b_q     <= 32'd0;
         out_op_q    <= 3'b000;
         out_rd_q    <= 5'd0;
         busy_q      <= 32'd0;
         zero_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_op_q    <= out_op_d;
         out_rd_q    <= out_rd_d;
         busy_q      <= busy_d;
         zero_q      <= zero_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (wb_hit && (int'(wb_rd) < NREG)) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_op    = out_op_q;
   assign out_rd    = out_rd_q;
   assign busy      = busy_q;
   assign zero_flag = zero_q;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; register addresses are 5 bits wide.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  an instruction is presented.
REQ-005 in_ready  output  1  the stage accepts the instruction this cycle.
REQ-006 in_op  input  3  ALU opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-007 in_rs, in_rt, in_rd  input  5 each  source A, source B and destination register indices.
REQ-008 out_valid  output  1  an operand bundle is presented to the ALU.
REQ-009 out_ready  input  1  the downstream ALU stage accepts the bundle.
REQ-010 out_a, out_b  output  32 each  operand values.
REQ-011 out_op  output  3  opcode passed through.
REQ-012 out_rd  output  5  destination passed through.
REQ-013 wb_en  input  1  a result is being written back.
REQ-014 wb_rd  input  5  write-back destination.
REQ-015 wb_data  input  32  ALU result.
REQ-016 wb_zero  input  1  ALU ex (zero) flag for the written-back result.
REQ-017 zero_flag  output  1  registered wb_zero from the last write-back with wb_en=1.
REQ-018 busy  output  32  scoreboard; bit i=1 means register i has a result pending.

Function
REQ-019 Register file: NREG x 32 bits; register 0 reads as 0 and ignores writes.
REQ-020 Write-back: when wb_en=1 and wb_rd!=0, regfile[wb_rd] and zero_flag update at the edge and busy[wb_rd] clears.
REQ-021 Hazard: hazard=1 when busy[in_rs], busy[in_rt] or busy[in_rd] is set for a non-zero index, subject to REQ-037.
REQ-022 in_ready = (!out_valid || out_ready) && !hazard; in_ready does not depend on in_valid.
REQ-023 Accept: the stage accepts when in_valid && in_ready.
REQ-024 Latency: on accept, out_a/out_b/out_op/out_rd load at the edge and out_valid=1 the next cycle (1-cycle latency).
REQ-025 Output hold: while out_valid && !out_ready, all out_* signals hold stable.
REQ-026 Output clear: when out_ready=1 and no accept occurs that cycle, out_valid clears at the edge.
REQ-027 Back-to-back: an accept in the same cycle as out_valid && out_ready sustains 1 instruction per cycle.
REQ-028 Scoreboard set: an accept with in_rd!=0 sets busy[in_rd].
REQ-029 Simultaneous scoreboard events: if the set and a write-back clear target the same register in one cycle, the set wins and busy stays 1.
REQ-030 Writes to register 0 are never tracked; busy[0] is always 0.
REQ-031 Arithmetic: the stage performs no arithmetic; operands pass through unmodified at full 32-bit width.

Reset
REQ-032 rst_n=0 asynchronously forces out_valid=0, out_a=out_b=0, out_op=000, out_rd=0, busy=0 and zero_flag=0.
REQ-033 Reset clears all regfile entries to 0.
REQ-034 An in-flight bundle or pending scoreboard entry is discarded on reset; no write-back is required afterwards.
REQ-035 in_ready is 1 on the first cycle after reset release.

Configuration
REQ-036 Macro ALU_OPERAND_BYPASS_EN selects write-back bypass.
REQ-037 With ALU_OPERAND_BYPASS_EN defined: a same-cycle write-back (wb_en=1) with wb_rd equal to in_rs or in_rt forwards wb_data into the captured operand, and that register does not raise hazard.
REQ-038 Without ALU_OPERAND_BYPASS_EN: the instruction stalls until the cycle after the write-back and reads the updated regfile, adding one cycle of latency.

Verification
REQ-039 Reset, wb r1=5, wb r2=7, then issue add rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_a=5, out_b=7, out_op=010, out_rd=3, busy[3]=1.
REQ-040 Issue rd=3, then an instruction with rs=3 -> in_ready=0 until wb rd=3 data=12. With bypass: accepted in the wb cycle, out_a=12. Without bypass: accepted one cycle later, out_a=12.
REQ-041 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* remain stable and in_ready=0; on release, the next instruction is accepted in the same cycle.
REQ-042 Write-back rd=0 data=0xFFFFFFFF, then issue rs=0 -> out_a=0 and busy[0]=0.
REQ-043 Issue rd=4 in the same cycle as wb rd=4 -> busy[4]=1 afterwards.
REQ-044 Write-back with wb_zero=1 sets zero_flag=1; assert rst_n=0 mid-stall -> out_valid, busy and zero_flag are 0 immediately, without waiting for a clock edge.
